// File: rtl/fp8_sched_pkg.sv
// Shared types and constants for the FP8 vector-multiplier scheduler.
// Default widths here size the response entry carried through the response FIFO.
package fp8_sched_pkg;

    localparam int SCHED_NREQ      = 2;
    localparam int SCHED_TAGW      = 4;
    localparam int SCHED_RSP_DEPTH = 4;
    localparam int SCHED_IDW       = $clog2(SCHED_NREQ);

    localparam logic [7:0]  FP8_E4M3_ONE = 8'h38;
    localparam logic [15:0] FP16_ONE     = 16'h3C00;

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        BURST = 1'b1
    } state_t;

    typedef struct packed {
        logic [63:0]           res;
        logic [SCHED_IDW-1:0]  id;
        logic [SCHED_TAGW-1:0] tag;
        logic                  last;
    } rsp_entry_t;

endpackage

// File: rtl/fp8_sched_rsp_fifo.sv
// Response FIFO: DEPTH entries of rsp_entry_t, head visible combinationally from storage,
// occupancy exported so the scheduler can budget credits.
module fp8_sched_rsp_fifo
    import fp8_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  rsp_entry_t               push_data,
    input  logic                     pop,
    output rsp_entry_t               head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    rsp_entry_t    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Pops on an empty FIFO are dropped; a push into a full one cannot happen under credit.
    assign do_pop_s  = pop && (count_r != '0);
    assign do_push_s = push && (count_r != (AW+1)'(DEPTH));

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/fp8_vecmul_scheduler.sv
// Round-robin, packet-locked scheduler sharing one external FP8 vector multiplier between
// NREQ requesters, with a registered operand stage and a credit-protected response FIFO.
module fp8_vecmul_scheduler
    import fp8_sched_pkg::*;
#(
    parameter int NREQ      = SCHED_NREQ,
    parameter int TAGW      = SCHED_TAGW,
    parameter int RSP_DEPTH = SCHED_RSP_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ-1:0]         req_last,
    input  logic [NREQ-1:0]         req_mode,
    input  logic [NREQ*8-1:0]       req_q,
    input  logic [NREQ*32-1:0]      req_vec,
    input  logic [NREQ*TAGW-1:0]    req_tag,
    output logic                    mul_e5m2mode,
    output logic [7:0]              mul_q,
    output logic [31:0]             mul_vec,
    input  logic [63:0]             mul_res,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [63:0]             rsp_res,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [TAGW-1:0]         rsp_tag,
    output logic                    rsp_last,
    output logic                    busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(RSP_DEPTH) + 1;

    state_t          state_r, state_n;
    logic [IDW-1:0]  rr_ptr_r, rr_ptr_n;
    logic [IDW-1:0]  lock_id_r, lock_id_n;
    logic            lock_mode_r, lock_mode_n;

    logic            s1_valid_r;
    logic [7:0]      s1_q_r;
    logic [31:0]     s1_vec_r;
    logic            s1_mode_r;
    logic [IDW-1:0]  s1_id_r;
    logic [TAGW-1:0] s1_tag_r;
    logic            s1_last_r;

    logic [CW-1:0]   fifo_count_s;
    logic [CW:0]     credit_used_s;
    logic            can_issue_s;
    logic            grant_valid_s;
    logic [IDW-1:0]  grant_id_s;
    logic [IDW-1:0]  sel_s;
    logic            hs_s;
    logic            issue_mode_s;
    logic [NREQ-1:0] req_ready_s;
    rsp_entry_t      push_entry_s;
    rsp_entry_t      head_s;

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        return (int'(id) == NREQ - 1) ? '0 : id + IDW'(1);
    endfunction

    // Credit counts only registered occupancy; holding reset also withholds every grant.
    assign credit_used_s = (CW+1)'(fifo_count_s) + (CW+1)'(s1_valid_r);
    assign can_issue_s   = rst && (credit_used_s < (CW+1)'(RSP_DEPTH));

    // Cyclic search for the first valid requester at or after the round-robin pointer.
    always_comb begin
        int idx;
        grant_valid_s = 1'b0;
        grant_id_s    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx           = (int'(rr_ptr_r) + k) % NREQ;
            grant_id_s    = (req_valid[idx] && !grant_valid_s) ? IDW'(idx) : grant_id_s;
            grant_valid_s = grant_valid_s | req_valid[idx];
        end
    end

    // Ready/handshake decode and next-state logic for the arbitration FSM.
    always_comb begin
        req_ready_s  = '0;
        sel_s        = grant_id_s;
        issue_mode_s = 1'b0;
        state_n      = state_r;
        rr_ptr_n     = rr_ptr_r;
        lock_id_n    = lock_id_r;
        lock_mode_n  = lock_mode_r;
        case (state_r)
            ARB: begin
                sel_s              = grant_id_s;
                req_ready_s[sel_s] = grant_valid_s & can_issue_s;
                issue_mode_s       = req_mode[sel_s];
            end
            BURST: begin
                sel_s              = lock_id_r;
                req_ready_s[sel_s] = can_issue_s;
                issue_mode_s       = lock_mode_r;
            end
            default: begin
                state_n = ARB;
            end
        endcase
        hs_s = req_valid[sel_s] & req_ready_s[sel_s];
        if (hs_s && req_last[sel_s]) begin
            state_n  = ARB;
            rr_ptr_n = next_id(sel_s);
        end else if (hs_s) begin
            state_n     = BURST;
            lock_id_n   = sel_s;
            lock_mode_n = issue_mode_s;
        end else begin
            lock_mode_n = lock_mode_r;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ARB;
            rr_ptr_r    <= '0;
            lock_id_r   <= '0;
            lock_mode_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            rr_ptr_r    <= rr_ptr_n;
            lock_id_r   <= lock_id_n;
            lock_mode_r <= lock_mode_n;
        end
    end

    // Operand stage: data holds between beats so the multiplier inputs stay quiet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_r <= 1'b0;
            s1_q_r     <= '0;
            s1_vec_r   <= '0;
            s1_mode_r  <= 1'b0;
            s1_id_r    <= '0;
            s1_tag_r   <= '0;
            s1_last_r  <= 1'b0;
        end else begin
            s1_valid_r <= hs_s;
            if (hs_s) begin
                s1_q_r    <= req_q[int'(sel_s)*8 +: 8];
                s1_vec_r  <= req_vec[int'(sel_s)*32 +: 32];
                s1_mode_r <= issue_mode_s;
                s1_id_r   <= sel_s;
                s1_tag_r  <= req_tag[int'(sel_s)*TAGW +: TAGW];
                s1_last_r <= req_last[sel_s];
            end
        end
    end

    // Multiplier result captured alongside the beat's sideband.
    always_comb begin
        push_entry_s      = '0;
        push_entry_s.res  = mul_res;
        push_entry_s.id   = s1_id_r;
        push_entry_s.tag  = s1_tag_r;
        push_entry_s.last = s1_last_r;
    end

    fp8_sched_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s1_valid_r),
        .push_data (push_entry_s),
        .pop       (rsp_ready),
        .head      (head_s),
        .count     (fifo_count_s)
    );

    assign req_ready    = req_ready_s;
    assign mul_e5m2mode = s1_mode_r;
    assign mul_q        = s1_q_r;
    assign mul_vec      = s1_vec_r;
    assign rsp_valid    = (fifo_count_s != '0);
    assign rsp_res      = head_s.res;
    assign rsp_id       = head_s.id;
    assign rsp_tag      = head_s.tag;
    assign rsp_last     = head_s.last;
    assign busy         = (state_r == BURST) || s1_valid_r || rsp_valid;

endmodule

// File: tb/tb_fp8_vecmul_scheduler.sv
// Scoreboard bench for fp8_vecmul_scheduler: packet-level arbitration model, FP8 multiplier
// model on the mul_* bus, and a monitor that checks every popped response in order.
module tb_fp8_vecmul_scheduler;
    import fp8_sched_pkg::*;

    localparam int N     = SCHED_NREQ;
    localparam int TW    = SCHED_TAGW;
    localparam int DEPTH = SCHED_RSP_DEPTH;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_mode;
    logic [N*8-1:0]    req_q;
    logic [N*32-1:0]   req_vec;
    logic [N*TW-1:0]   req_tag;
    logic              mul_e5m2mode;
    logic [7:0]        mul_q;
    logic [31:0]       mul_vec;
    logic [63:0]       mul_res;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [63:0]       rsp_res;
    logic [SCHED_IDW-1:0] rsp_id;
    logic [TW-1:0]     rsp_tag;
    logic              rsp_last;
    logic              busy;

    typedef struct {
        logic [63:0] res;
        int          id;
        logic [TW-1:0] tag;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: who owns the multiplier, whose turn is next, beats not yet popped.
    int   owner       = -1;
    int   rr          = 0;
    int   outstanding = 0;
    bit   acc_prev    = 1'b0;
    logic locked_mode = 1'b0;
    int   p_valid = 0, p_last = 100, p_ready = 100;

    fp8_vecmul_scheduler dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last), .req_mode(req_mode),
        .req_q(req_q), .req_vec(req_vec), .req_tag(req_tag),
        .mul_e5m2mode(mul_e5m2mode), .mul_q(mul_q), .mul_vec(mul_vec), .mul_res(mul_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_id(rsp_id),
        .rsp_tag(rsp_tag), .rsp_last(rsp_last), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void dec(input logic e5m2, input logic [7:0] x, output int e, output int m);
        int ef;
        if (e5m2) begin
            ef = int'(x[6:2]);
            m  = (((ef == 0) ? 0 : 4) + int'(x[1:0])) * 2;
            e  = (ef == 0) ? -14 : ef - 15;
        end else begin
            ef = int'(x[6:3]);
            m  = ((ef == 0) ? 0 : 8) + int'(x[2:0]);
            e  = (ef == 0) ? -6 : ef - 7;
        end
    endfunction

    // Exact for finite products in FP16 range; saturates to inf / flushes to zero otherwise.
    function automatic logic [15:0] fp8_mul(input logic e5m2, input logic [7:0] a, input logic [7:0] b);
        int ea, eb, ma, mb, p, k, e16, frac;
        logic s;
        s = a[7] ^ b[7];
        dec(e5m2, a, ea, ma);
        dec(e5m2, b, eb, mb);
        p = ma * mb;
        if (p == 0) return {s, 15'h0000};
        k = 0;
        for (int i = 0; i < 8; i++) if (p[i]) k = i;
        e16 = k - 6 + ea + eb + 15;
        if (e16 >= 31) return {s, 5'h1F, 10'h000};
        if (e16 <= 0) return {s, 15'h0000};
        frac = (p << (10 - k));
        return {s, e16[4:0], frac[9:0]};
    endfunction

    function automatic logic [63:0] mulvec(input logic m, input logic [7:0] q, input logic [31:0] v);
        logic [63:0] r;
        for (int l = 0; l < 4; l++) r[16*l +: 16] = fp8_mul(m, q, v[8*l +: 8]);
        return r;
    endfunction

    assign mul_res = mulvec(mul_e5m2mode, mul_q, mul_vec);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic new_beat(input int i);
        req_valid[i]        = 1'b1;
        req_q[8*i +: 8]     = 8'($urandom);
        req_vec[32*i +: 32] = $urandom;
        req_tag[TW*i +: TW] = TW'($urandom);
        req_mode[i]         = 1'($urandom);
        req_last[i]         = ($urandom_range(99) < p_last);
    endtask

    // One clock: check ready/valid/busy against the model, record any accepted beat, re-drive.
    task automatic step();
        logic [N-1:0] exp_ready;
        bit   credit, mrv, pop;
        int   hs_id, idx;
        exp_t e;
        @(negedge clk);
        credit    = outstanding < DEPTH;
        exp_ready = '0;
        if (owner >= 0) exp_ready[owner] = credit;
        else if (credit) begin
            for (int k = 0; k < N; k++) begin
                idx = (rr + k) % N;
                if (req_valid[idx] && exp_ready == '0) exp_ready[idx] = 1'b1;
            end
        end
        mrv = (outstanding - int'(acc_prev)) > 0;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("rsp_valid", 64'(rsp_valid), 64'(mrv));
        chk("busy", 64'(busy), 64'((owner >= 0) || (outstanding > 0)));
        hs_id = -1;
        for (int i = 0; i < N; i++) if (exp_ready[i] && req_valid[i]) hs_id = i;
        pop = mrv && rsp_ready;
        if (hs_id >= 0) begin
            e.res  = mulvec((owner >= 0) ? locked_mode : req_mode[hs_id],
                            req_q[8*hs_id +: 8], req_vec[32*hs_id +: 32]);
            e.id   = hs_id;
            e.tag  = req_tag[TW*hs_id +: TW];
            e.last = req_last[hs_id];
            sb.push_back(e);
            if (req_last[hs_id]) begin
                owner = -1;
                rr    = (hs_id + 1) % N;
            end else begin
                if (owner < 0) locked_mode = req_mode[hs_id];
                owner = hs_id;
            end
        end
        outstanding = outstanding + ((hs_id >= 0) ? 1 : 0) - (pop ? 1 : 0);
        acc_prev    = (hs_id >= 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs_id == i) begin
                if ($urandom_range(99) < p_valid) new_beat(i);
                else req_valid[i] = 1'b0;
            end else if (!req_valid[i] && ($urandom_range(99) < p_valid)) begin
                new_beat(i);
            end
        end
        rsp_ready = ($urandom_range(99) < p_ready);
    endtask

    // Monitor: every response the DUT hands over must be the oldest expected one.
    always @(negedge clk) begin
        exp_t e;
        if (rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("rsp_res", rsp_res, e.res);
                chk("rsp_id", 64'(rsp_id), 64'(e.id));
                chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
                chk("rsp_last", 64'(rsp_last), 64'(e.last));
            end
        end
    end

    initial begin
        rst = 1'b0; req_valid = '0; req_last = '0; req_mode = '0;
        req_q = '0; req_vec = '0; req_tag = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_mul_q", 64'(mul_q), 64'(0));
        chk("reset_mul_vec", 64'(mul_vec), 64'(0));
        chk("reset_mul_mode", 64'(mul_e5m2mode), 64'(0));
        chk("reset_rsp_res", rsp_res, 64'(0));

        // Single e4m3 beat: 1.0 x {2,1,2,1}.
        p_valid = 0;
        req_valid[0] = 1'b1; req_q[7:0] = FP8_E4M3_ONE; req_vec[31:0] = 32'h4038_4038;
        req_mode[0] = 1'b0; req_last[0] = 1'b1; req_tag[TW-1:0] = TW'(5);
        step();
        step();
        chk("single_res", rsp_res, {16'h4000, FP16_ONE, 16'h4000, FP16_ONE});
        chk("single_id", 64'(rsp_id), 64'(0));
        repeat (3) step();

        // Fairness with single-beat packets and an always-ready consumer.
        p_valid = 100; p_last = 100; p_ready = 100;
        for (int i = 0; i < N; i++) new_beat(i);
        repeat (20) step();

        // Back-pressure: credit must cap acceptance at DEPTH beats, then drain in order.
        p_ready = 0; p_last = 50; rsp_ready = 1'b0;
        repeat (10) step();
        p_ready = 100; rsp_ready = 1'b1;
        repeat (10) step();

        // Random multi-beat packets with per-beat mode changes and random consumer stalls.
        p_valid = 70; p_last = 35; p_ready = 60;
        repeat (400) step();

        // Reset in the middle of a packet with results still queued.
        p_valid = 100; p_last = 0; p_ready = 0; rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) if (!req_valid[i]) new_beat(i);
        repeat (4) step();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("midrst_req_ready", 64'(req_ready), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        sb.delete();
        owner = -1; rr = 0; outstanding = 0; acc_prev = 1'b0; locked_mode = 1'b0;
        p_last = 100; p_ready = 100;
        for (int i = 0; i < N; i++) begin
            new_beat(i);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (12) step();

        // Drain everything and confirm nothing was lost.
        p_valid = 0;
        repeat (12) step();
        chk("sb_drained", 64'(sb.size()), 64'(0));
        chk("final_rsp_valid", 64'(rsp_valid), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
